// File: rtl/mips_core_pkg.sv
// ============================================================================
// Module  : mips_core_pkg
// Purpose : Shared register-rename types, widths and reset constants.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mips_core_pkg;

   localparam int ARCH_REGS      = 32;
   localparam int PHYS_REGS      = 64;
   localparam int ARCH_REG_WIDTH = 5;
   localparam int PHYS_REG_WIDTH = 6;

   typedef logic [PHYS_REG_WIDTH-1:0] PhysReg;
   typedef logic [ARCH_REG_WIDTH-1:0] ArchReg;
   typedef logic [PHYS_REGS-1:0]      PhysVec;

   // Architectural regs start identity-mapped, so only the upper half is free.
   localparam PhysVec FREE_VEC_RESET  = {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
   localparam PhysVec READY_VEC_RESET = '1;

   function automatic PhysReg reset_map(input int idx);
      return PhysReg'(idx);
   endfunction

endpackage

`default_nettype wire

// File: rtl/phys_free_list.sv
// ============================================================================
// Module  : phys_free_list
// Purpose : Bit-vector free list with lowest-index allocation and flush reload.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module phys_free_list
   import mips_core_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   alloc,
   input  logic   free_valid,
   input  PhysReg free_phys,
   input  logic   flush,
   input  PhysVec flush_free_vec,
   output PhysReg alloc_phys,
   output logic   empty
);

   PhysVec r_free_vec;
   PhysVec w_free_next;

   // Descending scan leaves the lowest set index; bit 0 is never free.
   always_comb begin
      alloc_phys = '0;
      for (int i = PHYS_REGS-1; i >= 1; i--) begin
         if (r_free_vec[i]) alloc_phys = PhysReg'(i);
      end
   end

   assign empty = ~|r_free_vec;

   always_comb begin
      w_free_next = r_free_vec;
      if (alloc) w_free_next[alloc_phys] = 1'b0;
      if (free_valid && (free_phys != '0)) w_free_next[free_phys] = 1'b1;
      w_free_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_free_vec <= FREE_VEC_RESET;
      end else if (flush) begin
         r_free_vec <= flush_free_vec & ~PhysVec'(1);
      end else begin
         r_free_vec <= w_free_next;
      end
   end

endmodule

`default_nettype wire

// File: rtl/register_rename.sv
// ============================================================================
// Module  : register_rename
// Purpose : Single-issue rename stage with speculative/committed maps,
//           free list and physical-register ready vector.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module register_rename
   import mips_core_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_uses_rs,
   input  logic         in_uses_rt,
   input  logic         in_uses_rw,
   input  logic [4:0]   in_rs_addr,
   input  logic [4:0]   in_rt_addr,
   input  logic [4:0]   in_rw_addr,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_uses_rs,
   output logic         out_uses_rt,
   output logic         out_uses_rw,
   output logic [5:0]   out_rs_phys,
   output logic [5:0]   out_rt_phys,
   output logic [5:0]   out_rw_phys,
   output logic [5:0]   out_old_rw_phys,
   output logic         out_rs_ready,
   output logic         out_rt_ready,
   input  logic         wb_valid,
   input  logic [5:0]   wb_phys,
   input  logic         commit_valid,
   input  logic [4:0]   commit_rw_addr,
   input  logic [5:0]   commit_rw_phys,
   input  logic [5:0]   commit_old_phys,
   input  logic         flush,
   output logic [63:0]  phys_ready
);

   PhysReg r_spec_map   [ARCH_REGS];
   PhysReg r_commit_map [ARCH_REGS];
   PhysReg w_commit_map_next [ARCH_REGS];
   PhysVec r_ready_vec;
   PhysVec w_flush_free_vec;
   PhysVec w_used_vec;

   logic   r_out_valid;
   logic   r_uses_rs, r_uses_rt, r_uses_rw;
   PhysReg r_rs_phys, r_rt_phys, r_rw_phys, r_old_rw_phys;
   logic   r_rs_ready, r_rt_ready;

   logic   w_need_alloc;
   logic   w_xfer;
   logic   w_alloc;
   logic   w_commit;
   logic   w_fl_empty;
   PhysReg w_alloc_phys;
   PhysReg w_rs_phys, w_rt_phys, w_rw_phys, w_old_rw_phys;
   logic   w_rs_ready, w_rt_ready;

   assign w_need_alloc = in_uses_rw & (in_rw_addr != '0);
   assign in_ready     = ~flush & (~r_out_valid | out_ready) & (~w_need_alloc | ~w_fl_empty);
   assign w_xfer       = in_valid & in_ready;
   assign w_alloc      = w_xfer & w_need_alloc;
   assign w_commit     = commit_valid & (commit_rw_addr != '0);

   assign w_rs_phys     = r_spec_map[in_rs_addr];
   assign w_rt_phys     = r_spec_map[in_rt_addr];
   assign w_old_rw_phys = r_spec_map[in_rw_addr];
   assign w_rw_phys     = w_need_alloc ? w_alloc_phys : w_old_rw_phys;

   // Same-cycle writeback bypass so a waking producer is not missed.
   assign w_rs_ready = r_ready_vec[w_rs_phys] | (wb_valid & (wb_phys == w_rs_phys));
   assign w_rt_ready = r_ready_vec[w_rt_phys] | (wb_valid & (wb_phys == w_rt_phys));

   // Flush restores from the committed map including this cycle's retirement.
   always_comb begin
      for (int i = 0; i < ARCH_REGS; i++) w_commit_map_next[i] = r_commit_map[i];
      if (w_commit) w_commit_map_next[commit_rw_addr] = commit_rw_phys;
   end

   always_comb begin
      w_used_vec = '0;
      for (int i = 0; i < ARCH_REGS; i++) w_used_vec[w_commit_map_next[i]] = 1'b1;
      w_flush_free_vec = ~w_used_vec;
   end

   phys_free_list u_free_list (
      .clk            (clk),
      .rst            (rst),
      .alloc          (w_alloc),
      .free_valid     (w_commit),
      .free_phys      (commit_old_phys),
      .flush          (flush),
      .flush_free_vec (w_flush_free_vec),
      .alloc_phys     (w_alloc_phys),
      .empty          (w_fl_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            r_spec_map[i]   <= reset_map(i);
            r_commit_map[i] <= reset_map(i);
         end
      end else begin
         if (w_commit) r_commit_map[commit_rw_addr] <= commit_rw_phys;
         if (flush) begin
            for (int i = 0; i < ARCH_REGS; i++) r_spec_map[i] <= w_commit_map_next[i];
         end else if (w_alloc) begin
            r_spec_map[in_rw_addr] <= w_alloc_phys;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ready_vec <= READY_VEC_RESET;
      end else if (flush) begin
         r_ready_vec <= READY_VEC_RESET;
      end else begin
         if (w_alloc)  r_ready_vec[w_alloc_phys] <= 1'b0;
         if (wb_valid) r_ready_vec[wb_phys]      <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid   <= 1'b0;
         r_uses_rs     <= 1'b0;
         r_uses_rt     <= 1'b0;
         r_uses_rw     <= 1'b0;
         r_rs_phys     <= '0;
         r_rt_phys     <= '0;
         r_rw_phys     <= '0;
         r_old_rw_phys <= '0;
         r_rs_ready    <= 1'b0;
         r_rt_ready    <= 1'b0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_xfer) begin
         r_out_valid   <= 1'b1;
         r_uses_rs     <= in_uses_rs;
         r_uses_rt     <= in_uses_rt;
         r_uses_rw     <= in_uses_rw;
         r_rs_phys     <= w_rs_phys;
         r_rt_phys     <= w_rt_phys;
         r_rw_phys     <= w_rw_phys;
         r_old_rw_phys <= w_old_rw_phys;
         r_rs_ready    <= w_rs_ready;
         r_rt_ready    <= w_rt_ready;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid       = r_out_valid;
   assign out_uses_rs     = r_uses_rs;
   assign out_uses_rt     = r_uses_rt;
   assign out_uses_rw     = r_uses_rw;
   assign out_rs_phys     = r_rs_phys;
   assign out_rt_phys     = r_rt_phys;
   assign out_rw_phys     = r_rw_phys;
   assign out_old_rw_phys = r_old_rw_phys;
   assign out_rs_ready    = r_rs_ready;
   assign out_rt_ready    = r_rt_ready;
   assign phys_ready      = r_ready_vec;

endmodule

`default_nettype wire

// File: tb/tb_register_rename.sv
// ============================================================================
// Module  : tb_register_rename
// Purpose : Directed self-checking bench for register_rename.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_register_rename;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic        in_uses_rs, in_uses_rt, in_uses_rw;
   logic [4:0]  in_rs_addr, in_rt_addr, in_rw_addr;
   logic        out_valid, out_ready;
   logic        out_uses_rs, out_uses_rt, out_uses_rw;
   logic [5:0]  out_rs_phys, out_rt_phys, out_rw_phys, out_old_rw_phys;
   logic        out_rs_ready, out_rt_ready;
   logic        wb_valid;
   logic [5:0]  wb_phys;
   logic        commit_valid;
   logic [4:0]  commit_rw_addr;
   logic [5:0]  commit_rw_phys, commit_old_phys;
   logic        flush;
   logic [63:0] phys_ready;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [63:0] ALL_ONES = '1;

   register_rename dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_uses_rs      (in_uses_rs),
      .in_uses_rt      (in_uses_rt),
      .in_uses_rw      (in_uses_rw),
      .in_rs_addr      (in_rs_addr),
      .in_rt_addr      (in_rt_addr),
      .in_rw_addr      (in_rw_addr),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_uses_rs     (out_uses_rs),
      .out_uses_rt     (out_uses_rt),
      .out_uses_rw     (out_uses_rw),
      .out_rs_phys     (out_rs_phys),
      .out_rt_phys     (out_rt_phys),
      .out_rw_phys     (out_rw_phys),
      .out_old_rw_phys (out_old_rw_phys),
      .out_rs_ready    (out_rs_ready),
      .out_rt_ready    (out_rt_ready),
      .wb_valid        (wb_valid),
      .wb_phys         (wb_phys),
      .commit_valid    (commit_valid),
      .commit_rw_addr  (commit_rw_addr),
      .commit_rw_phys  (commit_rw_phys),
      .commit_old_phys (commit_old_phys),
      .flush           (flush),
      .phys_ready      (phys_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rename(input logic urs, input logic [4:0] rs,
                         input logic urt, input logic [4:0] rt,
                         input logic urw, input logic [4:0] rw);
      in_valid   = 1'b1;
      in_uses_rs = urs;  in_rs_addr = rs;
      in_uses_rt = urt;  in_rt_addr = rt;
      in_uses_rw = urw;  in_rw_addr = rw;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 0; in_uses_rs = 0; in_uses_rt = 0; in_uses_rw = 0;
      in_rs_addr = 0; in_rt_addr = 0; in_rw_addr = 0;
      out_ready = 1; wb_valid = 0; wb_phys = 0;
      commit_valid = 0; commit_rw_addr = 0; commit_rw_phys = 0; commit_old_phys = 0;
      flush = 0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_phys_ready", phys_ready, ALL_ONES);
      check("rst_rw_phys", out_rw_phys, 0);
      check("rst_old_rw", out_old_rw_phys, 0);
      rst = 1'b0;
      #1;
      check("idle_in_ready", in_ready, 1);

      // addu $3,$1,$2
      rename(1, 1, 1, 2, 1, 3);
      step(); idle();
      check("addu_valid", out_valid, 1);
      check("addu_rs", out_rs_phys, 1);
      check("addu_rt", out_rt_phys, 2);
      check("addu_rw", out_rw_phys, 32);
      check("addu_old", out_old_rw_phys, 3);
      check("addu_ready32", phys_ready[32], 0);
      check("addu_rs_rdy", out_rs_ready, 1);

      // consumer of $3, no bypass then with bypass
      rename(1, 3, 1, 1, 0, 0);
      step();
      check("dep_rs", out_rs_phys, 32);
      check("dep_rs_rdy", out_rs_ready, 0);
      check("dep_rt_rdy", out_rt_ready, 1);
      wb_valid = 1; wb_phys = 32;
      step(); wb_valid = 0; idle();
      check("byp_rs_rdy", out_rs_ready, 1);
      check("byp_ready32", phys_ready[32], 1);

      // write to $0 allocates nothing
      rename(0, 0, 0, 0, 1, 0);
      step();
      check("r0_rw", out_rw_phys, 0);
      check("r0_old", out_old_rw_phys, 0);
      check("r0_ready", phys_ready, ALL_ONES);
      rename(0, 0, 0, 0, 1, 4);
      step(); idle();
      check("r4_rw", out_rw_phys, 33);
      check("r4_old", out_old_rw_phys, 4);
      check("r4_ready33", phys_ready[33], 0);

      // flush drops the concurrent transfer
      rename(0, 0, 0, 0, 1, 9);
      flush = 1;
      #1;
      check("flush_in_ready", in_ready, 0);
      step(); flush = 0; idle();
      check("flush_out_valid", out_valid, 0);
      check("flush_ready", phys_ready, ALL_ONES);

      rename(1, 3, 0, 0, 1, 5);
      step();
      check("post_flush_rs3", out_rs_phys, 3);
      check("w5_rw", out_rw_phys, 32);
      check("w5_old", out_old_rw_phys, 5);
      rename(0, 0, 0, 0, 1, 6);
      step(); idle();
      check("w6_rw", out_rw_phys, 33);
      flush = 1;
      step(); flush = 0;
      rename(1, 5, 0, 0, 1, 7);
      step(); idle();
      check("w7_rs5", out_rs_phys, 5);
      check("w7_rw", out_rw_phys, 32);
      check("w7_old", out_old_rw_phys, 7);

      // exhaust the free list
      flush = 1;
      step(); flush = 0;
      for (int i = 0; i < 32; i++) begin
         rename(0, 0, 0, 0, 1, 5'((i % 31) + 1));
         step();
         check("fill_rw", out_rw_phys, 64'(32 + i));
      end
      rename(0, 0, 0, 0, 1, 2);
      #1;
      check("empty_in_ready", in_ready, 0);
      rename(1, 1, 0, 0, 0, 0);
      #1;
      check("empty_noalloc_ready", in_ready, 1);
      rename(0, 0, 0, 0, 1, 2);
      commit_valid = 1; commit_rw_addr = 3; commit_rw_phys = 34; commit_old_phys = 3;
      #1;
      check("commit_cycle_ready", in_ready, 0);
      step();
      commit_valid = 0;
      #1;
      check("freed_in_ready", in_ready, 1);
      step(); idle();
      check("freed_rw", out_rw_phys, 3);
      check("freed_old", out_old_rw_phys, 33);

      // flush restores to committed map with $3 -> 34
      flush = 1;
      step(); flush = 0;
      rename(1, 3, 0, 0, 1, 7);
      step();
      check("cmap_rs3", out_rs_phys, 34);
      check("cmap_rw", out_rw_phys, 3);
      check("cmap_old", out_old_rw_phys, 7);

      // backpressure hold
      rename(0, 0, 0, 0, 1, 8);
      step();
      check("hold_pre_rw", out_rw_phys, 32);
      out_ready = 0;
      rename(0, 0, 0, 0, 1, 9);
      #1;
      check("hold_in_ready", in_ready, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold_valid", out_valid, 1);
         check("hold_rw", out_rw_phys, 32);
         check("hold_old", out_old_rw_phys, 8);
         check("hold_in_rdy", in_ready, 0);
      end
      out_ready = 1;
      #1;
      check("release_in_ready", in_ready, 1);
      step();
      check("rel_w9_rw", out_rw_phys, 33);
      check("rel_w9_old", out_old_rw_phys, 9);
      rename(0, 0, 0, 0, 1, 10);
      step(); idle();
      check("rel_w10_rw", out_rw_phys, 35);
      check("rel_w10_old", out_old_rw_phys, 10);
      step();
      check("drain_valid", out_valid, 0);

      // asynchronous reset mid-cycle
      rename(0, 0, 0, 0, 1, 11);
      step(); idle();
      check("pre_arst_valid", out_valid, 1);
      #2 rst = 1;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_rw", out_rw_phys, 0);
      check("arst_ready", phys_ready, ALL_ONES);
      @(posedge clk);
      #1 rst = 0;
      rename(1, 3, 0, 0, 1, 3);
      step(); idle();
      check("after_rst_rs", out_rs_phys, 3);
      check("after_rst_rw", out_rw_phys, 32);
      check("after_rst_old", out_old_rw_phys, 3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/register_rename.md
# register_rename

Rename stage between decode and the instruction queue. Each cycle it accepts at most one decoded instruction and maps its architectural rs/rt/rw (32 entries) to physical registers (64 entries). It allocates a fresh physical destination from a bit-vector free list and exports the per-physical-register ready vector that the queue uses to wake up entries. It keeps a committed map so that a flush restores precise state in one cycle.

## Interface
- ARCH_REGS, 32, architectural register count (index width 5)
- PHYS_REGS, 64, physical register count (index width 6)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  rename accepts this cycle
- in_uses_rs, in_uses_rt, in_uses_rw  in  1 each  operand-use flags from decode
- in_rs_addr, in_rt_addr, in_rw_addr  in  5 each  architectural indices
- out_valid  out  1  renamed instruction held in the output register
- out_ready  in  1  instruction queue accepts
- out_uses_rs, out_uses_rt, out_uses_rw  out  1 each  registered copies of the use flags
- out_rs_phys, out_rt_phys, out_rw_phys  out  6 each  physical indices
- out_old_rw_phys  out  6  previous mapping of rw; the active list frees it at commit
- out_rs_ready, out_rt_ready  out  1 each  source readiness at rename time
- wb_valid, wb_phys  in  1, 6  writeback marks phys ready
- commit_valid, commit_rw_addr, commit_rw_phys, commit_old_phys  in  1, 5, 6, 6  retirement of a renamed destination
- flush  in  1  mispredict recovery
- phys_ready  out  64  ready bit per physical register

## Operation
- State:
  - spec_map[32] and commit_map[32], 6 bits each.
  - free_vec[64].
  - ready_vec[64], driven on phys_ready.
  - Output register with a valid bit.
- Reset values:
  - spec_map[i] = commit_map[i] = i.
  - free_vec bits 32..63 = 1, bits 0..31 = 0.
  - ready_vec all 1.
  - out_valid = 0.
  - All out_* data = 0.
- Handshake:
  - in_ready = ~flush & (~out_valid | out_ready) & (~need_alloc | free_vec != 0).
  - need_alloc = in_uses_rw & (in_rw_addr != 0).
  - A transfer occurs when in_valid & in_ready.
- On transfer:
  - Sources read spec_map as it stood before this edge.
  - rw_phys is the lowest set bit of free_vec when need_alloc; otherwise spec_map[rw_addr], which is 0 for $0.
  - old_rw_phys = spec_map[rw_addr].
  - If need_alloc: spec_map[rw] <= rw_phys, free_vec[rw_phys] <= 0, ready_vec[rw_phys] <= 0.
- Source ready = ready_vec[phys] | (wb_valid & wb_phys == phys). This is a same-cycle writeback bypass.
- wb_valid sets ready_vec[wb_phys].
- commit_valid (rw_addr != 0):
  - commit_map[rw] <= commit_rw_phys.
  - free_vec[commit_old_phys] <= 1.
  - A freed register becomes allocatable the next cycle.
- flush:
  - out_valid <= 0.
  - spec_map <= post-commit commit_map (this cycle's commit included).
  - free_vec <= complement of the set of registers named in the post-commit commit_map.
  - ready_vec <= all 1.
  - Any input transfer that cycle is dropped.
- Output hold: while out_valid & ~out_ready, all out_* stay stable.
- Physical register 0 is permanently mapped to $0, always ready, never allocated or freed.

## Timing
- Latency: 1 cycle from in transfer to out_valid. Throughput: 1 per cycle when out_ready stays high.
- Priority: rst > flush > commit/wb > allocate.
- wb and commit on the same register in one cycle are independent. Both take effect.
- Free list empty: in_ready is low only for instructions that need allocation. Others proceed.
- A reset asserted mid-operation clears everything asynchronously. The first transfer is allowed on the first edge after rst deasserts.

## Structure
- In mips_core_pkg:
  - `PHYS_REG_WIDTH = 6`.
  - `typedef logic [5:0] PhysReg`.
  - Reset mapping constants.
- Sub-module phys_free_list owns free_vec:
  - Lowest-index priority encoder for allocation.
  - empty flag.
  - free-on-commit.
  - flush reload.

## Test plan
- Reset, then rename addu $3,$1,$2 → next cycle out_rs_phys=1, out_rt_phys=2, out_rw_phys=32, out_old_rw_phys=3, phys_ready[32]=0.
- Next instruction reads $3 → out_rs_phys=32, out_rs_ready=0. With wb_valid, wb_phys=32 in the rename cycle → out_rs_ready=1.
- 32 allocating renames with no commit → 33rd sees in_ready=0. commit_old_phys=3 → one cycle later the 33rd is accepted with out_rw_phys=3.
- Rename writes to $5 and $6 (phys 32, 33), then flush with no commit → spec map restored. The next write to $7 gets phys 32, old 7.
- in_rw_addr=0 with uses_rw=1 → out_rw_phys=0, free_vec unchanged, ready_vec unchanged.
- out_ready=0 for 3 cycles with out_valid=1 → outputs stable, in_ready=0. Release → exactly one transfer per cycle, none lost or duplicated.
